// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC register write sequencer.
package rtc_pkg;

   localparam int ANCHO_CAMPO = 8;
   localparam logic [7:0] DIR_BASE_DEF = 8'h24;

   typedef enum logic [2:0] {
      ESPERA,
      CAPTURA,
      ARRANQUE,
      ESCRIBE,
      ESPERA_BUS,
      FIN
   } estado_t;

   function automatic logic es_bcd(input logic [7:0] valor);
      return (valor[7:4] <= 4'd9) && (valor[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/temporizador_ciclos.sv
// Cycle counter shared by the start-up wait and the write hold time.
module temporizador_ciclos #(
   parameter int ANCHO = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             limpiar,
   input  logic             contar,
   input  logic [ANCHO-1:0] limite,
   output logic             hecho
);

   logic [ANCHO-1:0] cuenta;

   // Clear has priority so the FSM can restart the count in any state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cuenta <= '0;
      end else if (limpiar) begin
         cuenta <= '0;
      end else if (contar) begin
         cuenta <= cuenta + 1'b1;
      end
   end

   assign hecho = (cuenta == limite);

endmodule

// File: rtl/escribir_registros_rtc.sv
// Captures BCD fields from the switches and writes the enabled ones to
// consecutive RTC registers through the bus controller handshake.
module escribir_registros_rtc
   import rtc_pkg::*;
#(
   parameter int         NUM_CAMPOS      = 4,
   parameter logic [7:0] DIR_BASE        = DIR_BASE_DEF,
   parameter int         CICLOS_ARRANQUE = 5,
   parameter int         CICLOS_HOLD     = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              siga,
   input  logic                              sw_cargar,
   input  logic [NUM_CAMPOS*ANCHO_CAMPO-1:0] sw_datos,
   input  logic [NUM_CAMPOS-1:0]             mascara,
   output logic [7:0]                        direc,
   output logic [7:0]                        dato,
   output logic [NUM_CAMPOS*ANCHO_CAMPO-1:0] vga_datos,
   output logic                              flag_rtc,
   output logic                              lea_escriba,
   output logic                              activo,
   output logic                              error_bcd,
   output logic                              listo
);

   localparam int ANCHO_DATOS = NUM_CAMPOS * ANCHO_CAMPO;

   estado_t                estado, estado_sig;
   logic [ANCHO_DATOS-1:0] sombra;
   logic [NUM_CAMPOS-1:0]  mascara_reg;
   logic [2:0]             indice, indice_sig, primero, siguiente;
   logic                   hay_siguiente, bcd_malo, error_set;
   logic                   t_limpiar, t_contar, t_hecho;
   logic [7:0]             limite;

   temporizador_ciclos #(.ANCHO(8)) u_temporizador (
      .clk     (clk),
      .reset   (reset),
      .limpiar (t_limpiar),
      .contar  (t_contar),
      .limite  (limite),
      .hecho   (t_hecho)
   );

   assign limite = (estado == ESCRIBE) ? 8'(CICLOS_HOLD - 1) : 8'(CICLOS_ARRANQUE);

   always_comb begin
      bcd_malo = 1'b0;
      for (int i = 0; i < NUM_CAMPOS; i++) begin
         if (mascara[i] && !es_bcd(sw_datos[i*ANCHO_CAMPO +: ANCHO_CAMPO])) begin
            bcd_malo = 1'b1;
         end
      end
   end

   // Scanning downwards leaves the lowest qualifying field in each result.
   always_comb begin
      primero       = '0;
      siguiente     = '0;
      hay_siguiente = 1'b0;
      for (int i = NUM_CAMPOS - 1; i >= 0; i--) begin
         if (mascara_reg[i]) begin
            primero = 3'(i);
            if (3'(i) > indice) begin
               siguiente     = 3'(i);
               hay_siguiente = 1'b1;
            end
         end
      end
   end

   always_comb begin
      estado_sig = estado;
      indice_sig = indice;
      t_limpiar  = 1'b1;
      t_contar   = 1'b0;
      error_set  = 1'b0;
      case (estado)
         ESPERA: begin
            if (sw_cargar) estado_sig = CAPTURA;
         end
         CAPTURA: begin
            if (!sw_cargar) begin
               if (bcd_malo) begin
                  error_set  = 1'b1;
                  estado_sig = ESPERA;
               end else if (mascara == '0) begin
                  estado_sig = ESPERA;
               end else begin
                  estado_sig = ARRANQUE;
               end
            end
         end
         ARRANQUE: begin
            if (sw_cargar) begin
               estado_sig = CAPTURA;
            end else if (t_hecho) begin
               estado_sig = ESCRIBE;
               indice_sig = primero;
            end else if (!siga) begin
               t_limpiar = 1'b0;
               t_contar  = 1'b1;
            end
         end
         ESCRIBE: begin
            if (t_hecho) begin
               estado_sig = ESPERA_BUS;
            end else begin
               t_limpiar = 1'b0;
               t_contar  = 1'b1;
            end
         end
         ESPERA_BUS: begin
            if (!siga) begin
               if (hay_siguiente) begin
                  estado_sig = ESCRIBE;
                  indice_sig = siguiente;
               end else begin
                  estado_sig = FIN;
               end
            end
         end
         FIN:     estado_sig = ESPERA;
         default: estado_sig = ESPERA;
      endcase
   end

   // The mask is frozen on arming so later switch changes cannot alter a running sequence.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado      <= ESPERA;
         indice      <= '0;
         sombra      <= '0;
         mascara_reg <= '0;
         error_bcd   <= 1'b0;
      end else begin
         estado <= estado_sig;
         indice <= indice_sig;
         if (estado == CAPTURA) sombra <= sw_datos;
         if (estado == CAPTURA && estado_sig == ARRANQUE) mascara_reg <= mascara;
         if (estado != CAPTURA && estado_sig == CAPTURA) begin
            error_bcd <= 1'b0;
         end else if (error_set) begin
            error_bcd <= 1'b1;
         end
      end
   end

   always_comb begin
      flag_rtc    = (estado == ESCRIBE);
      lea_escriba = (estado == ESCRIBE) || (estado == ESPERA_BUS);
      activo      = (estado == ARRANQUE) || lea_escriba;
      listo       = (estado == FIN);
      direc       = '0;
      dato        = '0;
      if (lea_escriba) begin
         direc = DIR_BASE + {5'b00000, indice};
         dato  = sombra[int'(indice)*ANCHO_CAMPO +: ANCHO_CAMPO];
      end
   end

   assign vga_datos = sombra;

endmodule

// File: tb/tb_escribir_registros_rtc.sv
// Scoreboard bench: expected writes are queued when a sequence is launched and checked as each bus write ends.
module tb_escribir_registros_rtc;

   typedef struct {
      logic [7:0] dir;
      logic [7:0] dato;
   } escritura_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        siga = 1'b0;
   logic        sw_cargar = 1'b0;
   logic [31:0] sw_datos = '0;
   logic [3:0]  mascara = '0;
   logic [7:0]  direc, dato;
   logic [31:0] vga_datos;
   logic        flag_rtc, lea_escriba, activo, error_bcd, listo;

   escritura_t exp_q[$];
   int errores = 0;
   int checks = 0;
   int n_listo = 0;
   int n_flag = 0;
   int n_arranque = 0;
   bit en_flag = 1'b0;
   int hold = 0;
   logic [7:0] cap_dir, cap_dato;

   escribir_registros_rtc #(
      .NUM_CAMPOS      (4),
      .DIR_BASE        (8'h24),
      .CICLOS_ARRANQUE (5),
      .CICLOS_HOLD     (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .siga        (siga),
      .sw_cargar   (sw_cargar),
      .sw_datos    (sw_datos),
      .mascara     (mascara),
      .direc       (direc),
      .dato        (dato),
      .vga_datos   (vga_datos),
      .flag_rtc    (flag_rtc),
      .lea_escriba (lea_escriba),
      .activo      (activo),
      .error_bcd   (error_bcd),
      .listo       (listo)
   );

   always #5 clk = ~clk;

   // Monitor: each completed flag_rtc pulse is popped against the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         en_flag = 1'b0;
         hold    = 0;
      end else begin
         if (flag_rtc) begin
            if (!en_flag) begin
               en_flag  = 1'b1;
               hold     = 0;
               cap_dir  = direc;
               cap_dato = dato;
               n_flag++;
            end
            hold++;
         end else if (en_flag) begin
            en_flag = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
               errores++;
               $display("[TB] FAIL unexpected_write: got dir=%h dato=%h, required no write", cap_dir, cap_dato);
            end else begin
               escritura_t e;
               e = exp_q.pop_front();
               if (cap_dir !== e.dir) begin
                  errores++;
                  $display("[TB] FAIL write_dir: got %h, required %h", cap_dir, e.dir);
               end
               checks++;
               if (cap_dato !== e.dato) begin
                  errores++;
                  $display("[TB] FAIL write_dato: got %h, required %h", cap_dato, e.dato);
               end
               checks++;
               if (hold !== 2) begin
                  errores++;
                  $display("[TB] FAIL flag_hold: got %0d cycles, required 2", hold);
               end
            end
         end
         if (listo) n_listo++;
         if (activo && !lea_escriba) n_arranque++;
      end
   end

   task automatic ciclos(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic limpiar_contadores();
      n_listo    = 0;
      n_flag     = 0;
      n_arranque = 0;
   endtask

   task automatic iniciar(input logic [31:0] datos, input logic [3:0] msk, input bit empujar);
      bit valido;
      escritura_t e;
      valido = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (msk[i] && ((datos[8*i+4 +: 4] > 4'd9) || (datos[8*i +: 4] > 4'd9))) valido = 1'b0;
      end
      if (empujar && valido) begin
         for (int i = 0; i < 4; i++) begin
            if (msk[i]) begin
               e.dir  = 8'h24 + 8'(i);
               e.dato = datos[8*i +: 8];
               exp_q.push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
      sw_datos  = datos;
      mascara   = msk;
      sw_cargar = 1'b1;
      ciclos(3);
      sw_cargar = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      checks++;
      if ({direc, dato, vga_datos, flag_rtc, lea_escriba, activo, error_bcd, listo} !== '0) begin
         errores++;
         $display("[TB] FAIL reset_outputs: got dir=%h dato=%h vga=%h flags=%b, required all 0",
                  direc, dato, vga_datos, {flag_rtc, lea_escriba, activo, error_bcd, listo});
      end
      @(negedge clk);
      reset = 1'b1;
      ciclos(3);
      checks++;
      if (activo !== 1'b0 || lea_escriba !== 1'b0) begin
         errores++;
         $display("[TB] FAIL reset_release_idle: got activo=%b lea=%b, required 0 0", activo, lea_escriba);
      end
   endtask

   task automatic test_escritura_completa();
      limpiar_contadores();
      iniciar(32'h03120417, 4'b1111, 1'b1);
      checks++;
      if (vga_datos !== 32'h03120417) begin
         errores++;
         $display("[TB] FAIL vga_capture: got %h, required 03120417", vga_datos);
      end
      ciclos(40);
      checks++;
      if (exp_q.size() != 0) begin
         errores++;
         $display("[TB] FAIL full_pending: got %0d writes missing, required 0", exp_q.size());
      end
      checks++;
      if (n_listo != 1) begin
         errores++;
         $display("[TB] FAIL full_listo: got %0d pulses, required 1", n_listo);
      end
      checks++;
      if (n_arranque != 6) begin
         errores++;
         $display("[TB] FAIL full_startup: got %0d cycles, required 6", n_arranque);
      end
      checks++;
      if (n_flag != 4) begin
         errores++;
         $display("[TB] FAIL full_flag_count: got %0d, required 4", n_flag);
      end
   endtask

   task automatic test_bcd_invalido();
      limpiar_contadores();
      iniciar(32'h0312043A, 4'b1111, 1'b1);
      ciclos(30);
      checks++;
      if (error_bcd !== 1'b1) begin
         errores++;
         $display("[TB] FAIL bcd_error_flag: got %b, required 1", error_bcd);
      end
      checks++;
      if (n_flag != 0 || n_listo != 0) begin
         errores++;
         $display("[TB] FAIL bcd_no_write: got flags=%0d listo=%0d, required 0 0", n_flag, n_listo);
      end
      checks++;
      if (activo !== 1'b0) begin
         errores++;
         $display("[TB] FAIL bcd_idle: got activo=%b, required 0", activo);
      end
   endtask

   task automatic test_mascara();
      limpiar_contadores();
      iniciar(32'h03120417, 4'b0101, 1'b1);
      checks++;
      if (error_bcd !== 1'b0) begin
         errores++;
         $display("[TB] FAIL mask_error_cleared: got %b, required 0", error_bcd);
      end
      ciclos(1);
      mascara = 4'b1111;
      ciclos(40);
      checks++;
      if (n_flag != 2) begin
         errores++;
         $display("[TB] FAIL mask_flag_count: got %0d, required 2", n_flag);
      end
      checks++;
      if (exp_q.size() != 0 || n_listo != 1) begin
         errores++;
         $display("[TB] FAIL mask_done: got pending=%0d listo=%0d, required 0 1", exp_q.size(), n_listo);
      end
   endtask

   task automatic test_sin_mascara();
      limpiar_contadores();
      iniciar(32'h11223344, 4'b0000, 1'b1);
      ciclos(30);
      checks++;
      if (n_flag != 0 || n_listo != 0 || error_bcd !== 1'b0) begin
         errores++;
         $display("[TB] FAIL nomask: got flags=%0d listo=%0d err=%b, required 0 0 0", n_flag, n_listo, error_bcd);
      end
   endtask

   task automatic test_siga_glitch();
      limpiar_contadores();
      iniciar(32'h09080706, 4'b1111, 1'b1);
      ciclos(4);
      siga = 1'b1;
      ciclos(1);
      siga = 1'b0;
      ciclos(40);
      checks++;
      if (n_arranque != 10) begin
         errores++;
         $display("[TB] FAIL glitch_startup: got %0d cycles, required 10", n_arranque);
      end
      checks++;
      if (exp_q.size() != 0 || n_listo != 1) begin
         errores++;
         $display("[TB] FAIL glitch_done: got pending=%0d listo=%0d, required 0 1", exp_q.size(), n_listo);
      end
   endtask

   task automatic test_abort();
      limpiar_contadores();
      iniciar(32'h11223344, 4'b1111, 1'b0);
      ciclos(2);
      sw_cargar = 1'b1;
      sw_datos  = 32'h59484736;
      ciclos(3);
      checks++;
      if (vga_datos !== 32'h59484736 || activo !== 1'b0) begin
         errores++;
         $display("[TB] FAIL abort_capture: got vga=%h activo=%b, required 59484736 0", vga_datos, activo);
      end
      iniciar(32'h59484736, 4'b1111, 1'b1);
      ciclos(40);
      checks++;
      if (exp_q.size() != 0 || n_listo != 1 || n_flag != 4) begin
         errores++;
         $display("[TB] FAIL abort_done: got pending=%0d listo=%0d flags=%0d, required 0 1 4",
                  exp_q.size(), n_listo, n_flag);
      end
   endtask

   task automatic test_reset_escritura();
      bit visto;
      limpiar_contadores();
      visto = 1'b0;
      iniciar(32'h03120417, 4'b1111, 1'b1);
      for (int i = 0; i < 50 && !visto; i++) begin
         @(negedge clk);
         if (flag_rtc) visto = 1'b1;
      end
      checks++;
      if (!visto) begin
         errores++;
         $display("[TB] FAIL midreset_wait: got no flag_rtc in 50 cycles, required flag_rtc=1");
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({direc, dato, vga_datos, flag_rtc, lea_escriba, activo, error_bcd, listo} !== '0) begin
         errores++;
         $display("[TB] FAIL midreset_outputs: got dir=%h dato=%h vga=%h flags=%b, required all 0",
                  direc, dato, vga_datos, {flag_rtc, lea_escriba, activo, error_bcd, listo});
      end
      exp_q.delete();
      @(negedge clk);
      #1;
      reset = 1'b1;
      ciclos(3);
      checks++;
      if (activo !== 1'b0 || flag_rtc !== 1'b0) begin
         errores++;
         $display("[TB] FAIL midreset_release: got activo=%b flag=%b, required 0 0", activo, flag_rtc);
      end
   endtask

   initial begin
      test_reset();
      test_escritura_completa();
      test_bcd_invalido();
      test_mascara();
      test_sin_mascara();
      test_siga_glitch();
      test_abort();
      test_reset_escritura();
      $display("Result: errors=%0d of %0d checks", errores, checks);
      $finish;
   end

endmodule
